// File: rtl/i2c_master_burst_if.sv
// Host-side bundle of the burst I2C master.
//   master modport : the I2C engine (consumes requests, drives pads/status)
//   slave  modport : the requester/pad side (issues requests, returns SDA)
// Request handshake: the host raises start for at least one cycle while
// busy=0; that cycle captures rw/dev_addr/reg_addr/num_bytes/wr_data.
// busy is high from the next cycle until done pulses for exactly one cycle
// (busy already low in that cycle). ack_err and rd_data are valid with done.
// start is ignored while busy=1.
// state_dbg exposes the engine's FSM state for observation.
interface i2c_master_burst_if #(
  parameter int ADDR_BYTES = 2,
  parameter int MAX_BURST  = 4,
  parameter int CW         = $clog2(MAX_BURST + 1)
);
  logic                      start;
  logic                      rw;
  logic [6:0]                dev_addr;
  logic [8*ADDR_BYTES-1:0]   reg_addr;
  logic [CW-1:0]             num_bytes;
  logic [8*MAX_BURST-1:0]    wr_data;
  logic [8*MAX_BURST-1:0]    rd_data;
  logic                      busy;
  logic                      done;
  logic                      ack_err;
  logic                      scl_oe;
  logic                      sda_oe;
  logic                      sda_i;
  logic [3:0]                state_dbg;

  modport master (
    input  start, rw, dev_addr, reg_addr, num_bytes, wr_data, sda_i,
    output rd_data, busy, done, ack_err, scl_oe, sda_oe, state_dbg
  );

  modport slave (
    output start, rw, dev_addr, reg_addr, num_bytes, wr_data, sda_i,
    input  rd_data, busy, done, ack_err, scl_oe, sda_oe, state_dbg
  );
endinterface

// File: rtl/i2c_master_burst.sv
// Burst I2C master for camera-sensor register access.
// Sends START, {dev,W}, ADDR_BYTES register-address bytes, then either
// N write bytes or a repeated START, {dev,R} and N read bytes, then STOP.
// Every bus phase (START, RSTART, STOP, one bit) is four quarters of
// QTR_DIV sys_clk cycles each.
// Ports:
//   sys_clk : rising-edge clock
//   reset   : synchronous active-high reset (aborts without STOP)
//   bus     : i2c_master_burst_if.master (request, status, pad controls)
module i2c_master_burst #(
  parameter int QTR_DIV    = 250,
  parameter int ADDR_BYTES = 2,
  parameter int MAX_BURST  = 4,
  parameter int CW         = $clog2(MAX_BURST + 1)
) (
  input logic              sys_clk,
  input logic              reset,
  i2c_master_burst_if.master bus
);
  localparam int TW = $clog2(QTR_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_REJECT, S_START, S_DEVW, S_REGADDR, S_WDATA,
    S_RSTART, S_DEVR, S_RDATA, S_STOP
  } state_t;

  state_t                  state, state_nx;
  logic [TW-1:0]           cnt;
  logic [1:0]              q;
  logic [3:0]              bit_idx;
  logic [CW-1:0]           byte_idx;
  logic                    rw_q;
  logic [6:0]              dev_q;
  logic [8*ADDR_BYTES-1:0] reg_q;
  logic [CW-1:0]           num_q;
  logic [8*MAX_BURST-1:0]  wr_q;
  logic [8*MAX_BURST-1:0]  rd_q;
  logic [6:0]              rx_sh;
  logic                    nack_q;
  logic                    done_q;
  logic                    ack_err_q;

  logic [CW-1:0] num_clamped;
  logic          reject;
  logic          qtr_end, phase_end, byte_end, sample;
  logic          byte_state, tx_state, last_reg, last_data;
  logic [7:0]    tx_byte;
  logic          tx_bit;

  assign num_clamped = (32'(bus.num_bytes) > MAX_BURST) ? CW'(MAX_BURST) : bus.num_bytes;
  assign reject      = bus.rw && (num_clamped == '0);

  assign qtr_end   = (cnt == TW'(QTR_DIV - 1));
  assign phase_end = qtr_end && (q == 2'd3);
  assign sample    = qtr_end && (q == 2'd2);
  assign byte_end  = phase_end && (bit_idx == 4'd8);

  assign byte_state = (state == S_DEVW) || (state == S_REGADDR) || (state == S_WDATA) ||
                      (state == S_DEVR) || (state == S_RDATA);
  assign tx_state   = byte_state && (state != S_RDATA);
  assign last_reg   = (32'(byte_idx) == ADDR_BYTES - 1);
  assign last_data  = (byte_idx == num_q - CW'(1));

  // Byte currently on the wire when the master is the transmitter.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_DEVW:    tx_byte = {dev_q, 1'b0};
      S_DEVR:    tx_byte = {dev_q, 1'b1};
      S_REGADDR: tx_byte = reg_q[8*(ADDR_BYTES-1-32'(byte_idx)) +: 8];
      S_WDATA:   tx_byte = wr_q[8*32'(byte_idx) +: 8];
      default:   tx_byte = 8'h00;
    endcase
    tx_bit = tx_byte[3'(7 - 32'(bit_idx))];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (bus.start) state_nx = reject ? S_REJECT : S_START;
      S_REJECT:  state_nx = S_IDLE;
      S_START:   if (phase_end) state_nx = S_DEVW;
      S_DEVW:    if (byte_end) state_nx = nack_q ? S_STOP : S_REGADDR;
      S_REGADDR: if (byte_end) begin
                   if (nack_q)        state_nx = S_STOP;
                   else if (last_reg) state_nx = rw_q ? S_RSTART :
                                                 ((num_q == '0) ? S_STOP : S_WDATA);
                 end
      S_WDATA:   if (byte_end && (nack_q || last_data)) state_nx = S_STOP;
      S_RSTART:  if (phase_end) state_nx = S_DEVR;
      S_DEVR:    if (byte_end) state_nx = nack_q ? S_STOP : S_RDATA;
      S_RDATA:   if (byte_end && last_data) state_nx = S_STOP;
      S_STOP:    if (phase_end) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Pad drive per phase/quarter. In bit phases SCL is low in q0 and q3.
  always_comb begin
    bus.scl_oe = 1'b0;
    bus.sda_oe = 1'b0;
    case (state)
      S_START: begin
        bus.scl_oe = (q == 2'd3);
        bus.sda_oe = (q != 2'd0);
      end
      S_RSTART: begin
        // SCL low with SDA free, raise SCL, then SDA falls while SCL high.
        bus.scl_oe = (q == 2'd0) || (q == 2'd3);
        bus.sda_oe = (q >= 2'd2);
      end
      S_DEVW, S_REGADDR, S_WDATA, S_DEVR: begin
        bus.scl_oe = (q == 2'd0) || (q == 2'd3);
        bus.sda_oe = (bit_idx == 4'd8) ? 1'b0 : ~tx_bit;
      end
      S_RDATA: begin
        // ACK every byte except the last, which is left NACKed.
        bus.scl_oe = (q == 2'd0) || (q == 2'd3);
        bus.sda_oe = (bit_idx == 4'd8) && !last_data;
      end
      S_STOP: begin
        bus.scl_oe = (q == 2'd0);
        bus.sda_oe = (q <= 2'd1);
      end
      default: begin
        bus.scl_oe = 1'b0;
        bus.sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      q         <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      num_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      rx_sh     <= '0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        cnt      <= '0;
        q        <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
        if (bus.start) begin
          rw_q      <= bus.rw;
          dev_q     <= bus.dev_addr;
          reg_q     <= bus.reg_addr;
          num_q     <= num_clamped;
          wr_q      <= bus.wr_data;
          ack_err_q <= reject;
          done_q    <= reject;
        end
      end else if (state != S_REJECT) begin
        cnt <= qtr_end ? '0 : cnt + 1'b1;
        if (qtr_end) q <= q + 2'd1;
        if (sample && byte_state) begin
          if (bit_idx == 4'd8) begin
            if (tx_state) begin
              nack_q <= bus.sda_i;
              if (bus.sda_i) ack_err_q <= 1'b1;
            end
          end else if (state == S_RDATA) begin
            rx_sh <= {rx_sh[5:0], bus.sda_i};
            if (bit_idx == 4'd7) rd_q[8*32'(byte_idx) +: 8] <= {rx_sh, bus.sda_i};
          end
        end
        if (phase_end && byte_state) begin
          if (bit_idx == 4'd8) begin
            bit_idx  <= '0;
            byte_idx <= (state_nx == state) ? byte_idx + CW'(1) : '0;
          end else begin
            bit_idx <= bit_idx + 4'd1;
          end
        end
        if ((state == S_STOP) && phase_end) done_q <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.rd_data   = rd_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_i2c_master_burst.sv
module tb_i2c_master_burst;
  localparam int QTR_DIV    = 4;
  localparam int ADDR_BYTES = 2;
  localparam int MAX_BURST  = 4;
  localparam int CW         = $clog2(MAX_BURST + 1);
  localparam logic [8:0] TOK_START = 9'h100;
  localparam logic [8:0] TOK_STOP  = 9'h101;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  i2c_master_burst_if #(.ADDR_BYTES(ADDR_BYTES), .MAX_BURST(MAX_BURST), .CW(CW)) bus ();

  i2c_master_burst #(.QTR_DIV(QTR_DIV), .ADDR_BYTES(ADDR_BYTES), .MAX_BURST(MAX_BURST), .CW(CW))
    dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic       exp_mack_q[$];
  logic       mack_q[$];
  logic [7:0] slave_rd_q[$];
  logic [8*MAX_BURST-1:0] exp_rd = '0;

  // ---------------- bus lines and slave model ----------------
  logic slave_pull;
  logic scl_l, sda_l;
  assign scl_l     = ~bus.scl_oe;
  assign sda_l     = ~(bus.sda_oe | slave_pull);
  assign bus.sda_i = sda_l;

  int         s_bit, s_wr_cnt, s_nack_at, bus_act;
  logic [7:0] s_sh, s_tx;
  logic       s_first, s_rd_active, s_goread, s_mack, prev_scl, prev_sda;

  task automatic slave_reset();
    s_bit = 0; s_sh = '0; s_tx = '0; s_first = 0; s_rd_active = 0; s_goread = 0;
    s_mack = 1; slave_pull = 0; s_wr_cnt = 0; s_nack_at = -1;
  endtask

  function automatic logic [7:0] next_rd();
    if (slave_rd_q.size() > 0) return slave_rd_q.pop_front();
    return 8'hFF;
  endfunction

  task automatic slave_step();
    logic cs, cd;
    cs = scl_l; cd = sda_l;
    if (bus.scl_oe || bus.sda_oe) bus_act++;
    if (cs && prev_scl && prev_sda && !cd) begin
      obs_q.push_back(TOK_START);
      s_bit = 0; s_first = 1; s_rd_active = 0; s_goread = 0; slave_pull = 0;
    end else if (cs && prev_scl && !prev_sda && cd) begin
      obs_q.push_back(TOK_STOP);
      s_rd_active = 0; slave_pull = 0;
    end else if (cs && !prev_scl) begin
      if (s_bit < 8) s_sh = {s_sh[6:0], cd};
      else if (s_bit == 8 && s_rd_active) begin
        s_mack = cd;
        mack_q.push_back(cd);
      end
      if (s_bit < 9) s_bit++;
    end else if (!cs && prev_scl) begin
      if (s_bit >= 1 && s_bit <= 7) begin
        if (s_rd_active) slave_pull = ~s_tx[3'(7 - s_bit)];
      end else if (s_bit == 8) begin
        if (s_rd_active) slave_pull = 0;
        else begin
          obs_q.push_back({1'b0, s_sh});
          slave_pull = (s_wr_cnt != s_nack_at);
          if (s_first && s_sh[0] && slave_pull) s_goread = 1;
          s_first = 0;
          s_wr_cnt++;
        end
      end else if (s_bit == 9) begin
        s_bit = 0; slave_pull = 0;
        if (s_rd_active) begin
          if (!s_mack) begin s_tx = next_rd(); slave_pull = ~s_tx[7]; end
          else s_rd_active = 0;
        end else if (s_goread) begin
          s_goread = 0; s_rd_active = 1; s_tx = next_rd(); slave_pull = ~s_tx[7];
        end
      end
    end
    prev_scl = cs; prev_sda = cd;
  endtask

  initial begin
    slave_reset();
    prev_scl = 1; prev_sda = 1; bus_act = 0;
    forever begin
      @(negedge sys_clk);
      slave_step();
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver + reference model ----------------
  task automatic do_xfer(input logic rw, input logic [6:0] dev, input logic [15:0] rega,
                         input int n, input logic [31:0] wr, input int nack_at,
                         input logic poke, input logic [31:0] rd_src);
    int n_eff, on_bus, lat, act0, m;
    logic rstart, err, got_done;
    logic [7:0] txl[$];
    n_eff = (n > MAX_BURST) ? MAX_BURST : n;
    exp_q.delete(); obs_q.delete(); mack_q.delete(); exp_mack_q.delete(); slave_rd_q.delete();
    for (int i = 0; i < n_eff; i++) slave_rd_q.push_back(rd_src[8*i +: 8]);
    err = 0; on_bus = 0; rstart = 0;
    if (rw && n_eff == 0) err = 1;
    else begin
      txl.push_back({dev, 1'b0});
      for (int a = 0; a < ADDR_BYTES; a++) txl.push_back(rega[8*(ADDR_BYTES-1-a) +: 8]);
      if (!rw) for (int i = 0; i < n_eff; i++) txl.push_back(wr[8*i +: 8]);
      else txl.push_back({dev, 1'b1});
      exp_q.push_back(TOK_START);
      for (int i = 0; i < txl.size(); i++) begin
        if (rw && i == 1 + ADDR_BYTES) begin exp_q.push_back(TOK_START); rstart = 1; end
        exp_q.push_back({1'b0, txl[i]});
        on_bus++;
        if (i == nack_at) begin err = 1; break; end
      end
      if (rw && !err) begin
        on_bus += n_eff;
        for (int i = 0; i < n_eff; i++) begin
          exp_mack_q.push_back(i == n_eff - 1);
          exp_rd[8*i +: 8] = rd_src[8*i +: 8];
        end
      end
      exp_q.push_back(TOK_STOP);
    end
    s_wr_cnt = 0; s_nack_at = nack_at; act0 = bus_act;

    @(posedge sys_clk); #1;
    bus.rw = rw; bus.dev_addr = dev; bus.reg_addr = rega; bus.num_bytes = CW'(n);
    bus.wr_data = wr; bus.start = 1'b1;
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    chk("busy_after_capture", bus.busy, 1);
    if (rw && n_eff == 0) begin
      chk("reject_done", bus.done, 1);
      chk("reject_ack_err", bus.ack_err, 1);
      @(posedge sys_clk); #1;
      chk("reject_busy_drop", bus.busy, 0);
      chk("reject_done_drop", bus.done, 0);
      chk("reject_no_bus_activity", bus_act - act0, 0);
      chk("reject_rd_data", bus.rd_data, exp_rd);
      return;
    end
    lat = 0; got_done = 0;
    while (lat < 20000 && !got_done) begin
      @(posedge sys_clk); #1;
      lat++;
      if (poke && lat == 100) begin
        bus.start = 1'b1; bus.dev_addr = dev ^ 7'h55; bus.wr_data = ~wr;
        bus.num_bytes = CW'(1); bus.rw = ~rw; bus.reg_addr = ~rega;
      end else bus.start = 1'b0;
      if (bus.done) got_done = 1;
    end
    chk("done_seen", got_done, 1);
    chk("latency", lat, 4 * QTR_DIV * (2 + 9 * on_bus + int'(rstart)));
    chk("busy_low_with_done", bus.busy, 0);
    chk("ack_err", bus.ack_err, err);
    @(posedge sys_clk); #1;
    chk("done_one_cycle", bus.done, 0);
    chk("ack_err_held", bus.ack_err, err);
    chk("rd_data", bus.rd_data, exp_rd);
    chk("token_count", obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("token%0d", i), obs_q[i], exp_q[i]);
    chk("master_ack_count", mack_q.size(), exp_mack_q.size());
    m = (mack_q.size() < exp_mack_q.size()) ? mack_q.size() : exp_mack_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("master_ack%0d", i), mack_q[i], exp_mack_q[i]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int dones, rw_r, n_r, tot, na;
    bus.start = 0; bus.rw = 0; bus.dev_addr = '0; bus.reg_addr = '0;
    bus.num_bytes = '0; bus.wr_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_scl_oe", bus.scl_oe, 0);
    chk("reset_sda_oe", bus.sda_oe, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_ack_err", bus.ack_err, 0);
    chk("reset_rd_data", bus.rd_data, 0);
    reset = 1'b0;

    do_xfer(1'b0, 7'h3C, 16'h3008, 1, 32'h0000_0082, -1, 1'b0, 32'h0);
    do_xfer(1'b1, 7'h3C, 16'h300A, 2, 32'h0, -1, 1'b0, 32'h0000_4056);
    chk("read_rd_low16", {48'h0, bus.rd_data[15:0]}, 64'h4056);
    do_xfer(1'b0, 7'h3C, 16'h3008, 2, 32'h0000_BEEF, 0, 1'b0, 32'h0);
    do_xfer(1'b0, 7'h3C, 16'h1234, 7, 32'hA1B2_C3D4, -1, 1'b1, 32'h0);

    // Abort in the register-address phase (starts 160 cycles after capture).
    @(posedge sys_clk); #1;
    bus.rw = 0; bus.dev_addr = 7'h21; bus.reg_addr = 16'h5A5A; bus.num_bytes = CW'(2);
    bus.wr_data = 32'h1122_3344; bus.start = 1;
    @(posedge sys_clk); #1;
    bus.start = 0; dones = 0;
    repeat (250) begin @(posedge sys_clk); #1; if (bus.done) dones++; end
    reset = 1'b1;
    @(posedge sys_clk); #1;
    chk("midreset_scl_oe", bus.scl_oe, 0);
    chk("midreset_sda_oe", bus.sda_oe, 0);
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    chk("midreset_rd_data", bus.rd_data, 0);
    exp_rd = '0;
    reset = 1'b0;
    repeat (40) begin @(posedge sys_clk); #1; if (bus.done) dones++; end
    chk("midreset_no_done", dones, 0);
    slave_reset(); obs_q.delete(); mack_q.delete();
    do_xfer(1'b0, 7'h50, 16'hABCD, 3, $urandom, -1, 1'b0, 32'h0);

    do_xfer(1'b1, 7'h3C, 16'h0100, 0, 32'h0, -1, 1'b0, 32'h0);
    do_xfer(1'b0, 7'h1A, 16'h00FF, 0, 32'h0, -1, 1'b0, 32'h0);
    do_xfer(1'b1, 7'h3C, 16'h300A, 3, 32'h0, 3, 1'b0, 32'h0099_8877);

    for (int t = 0; t < 12; t++) begin
      rw_r = $urandom_range(0, 1);
      n_r  = $urandom_range(0, 5);
      tot  = 1 + ADDR_BYTES + (rw_r ? 1 : ((n_r > MAX_BURST) ? MAX_BURST : n_r));
      na   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tot - 1) : -1;
      do_xfer(rw_r[0], 7'($urandom), 16'($urandom), n_r, $urandom, na, 1'b0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_master_burst.md
Name: i2c_master_burst

Overview:
Parametrised I2C master for camera-sensor register access, the successor to the single-shot transmit block. Supports single and burst writes and reads (repeated-start), 8- or 16-bit register addresses, and a configurable SCL rate. It sits between the control FSM/host registers and the open-drain SCL/SDA pads. It reports per-transfer completion and ACK errors.

Parameters:
QTR_DIV, 250, sys_clk cycles per quarter SCL period (100 MHz / (4*250) = 100 kHz); must be >= 2.
ADDR_BYTES, 2, register-address bytes sent after the device address (1 or 2).
MAX_BURST, 4, maximum data bytes per transfer.
CW, $clog2(MAX_BURST+1), width of num_bytes.

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a transfer; sampled only while busy=0.
rw  in  1  0 = write, 1 = read (write reg address, repeated start, read).
dev_addr  in  7  7-bit device address.
reg_addr  in  8*ADDR_BYTES  register address, MS byte sent first.
num_bytes  in  CW  data byte count.
wr_data  in  8*MAX_BURST  byte i = [8i+7:8i]; byte 0 is sent first.
rd_data  out  8*MAX_BURST  byte i = i-th byte received.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse at the end of a transfer.
ack_err  out  1  valid with done; 1 = NACK or rejected request.
scl_oe  out  1  1 = pull SCL low; 0 = release.
sda_oe  out  1  1 = pull SDA low; 0 = release.
sda_i  in  1  SDA pad input.

Behaviour:
- Reset (synchronous; applies the cycle after reset is sampled high, including mid-transfer): scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rd_data=0, state IDLE, tick counter 0. No STOP is generated when reset aborts a transfer.
- Tick generator: counter runs 0..QTR_DIV-1 only while busy. Each wrap is one quarter phase q0..q3.
- Request capture:
  - start=1 in IDLE latches rw, dev_addr, reg_addr, num_bytes and wr_data. busy=1 from the next cycle.
  - start while busy is ignored. Latched values are immune to later input changes.
- Request rules:
  - num_bytes > MAX_BURST is clamped to MAX_BURST.
  - rw=0 with num_bytes=0 is an address-only write.
  - rw=1 with num_bytes=0 is rejected: no bus activity; done=1 and ack_err=1 on the cycle after capture; busy=1 for that single cycle.
- State sequence: IDLE -> START -> DEVW -> REGADDR (x ADDR_BYTES) -> then one of:
  - write: WDATA (x N) -> STOP -> IDLE
  - read: RSTART -> DEVR -> RDATA (x N) -> STOP -> IDLE
- START (4 quarters): q0 SCL and SDA released; q1 SDA low; q2 hold; q3 SCL low.
- RSTART: q0 SCL low with SDA released; then follows the START pattern.
- Byte states are 9 bits (8 data MSB-first + ACK). Each bit is 4 quarters:
  - q0: SCL low, SDA updated.
  - q1: SCL released.
  - q2: SDA sampled.
  - q3: SCL low.
- Device byte: DEVW = {dev_addr,0}; DEVR = {dev_addr,1}.
- ACK handling on transmit: SDA released in the 9th bit. If sda_i=1 at q2, set ack_err=1 and go straight to STOP.
- Read bytes: SDA released for 8 bits, sampled into rd_data byte i. The master drives ACK (sda_oe=1) after each byte except the last, which gets NACK (released).
- STOP (4 quarters): q0 SDA low, SCL low; q1 SCL released; q2 SDA released; q3 idle.
- Completion: done=1 for exactly one cycle after STOP q3 ends; busy=0 the same cycle. ack_err holds its value until the next start capture clears it.
- Latency: a write of N bytes with no NACK takes 4*QTR_DIV*(2 + 9*(1+ADDR_BYTES+N)) cycles from busy rise to done. A read adds 4*QTR_DIV*(1 + 9) for RSTART and DEVR.
- No clock stretching: the master never samples SCL.

Test Plan:
- QTR_DIV=4, ADDR_BYTES=2; write dev 0x3C, reg 0x3008, N=1, data 0x82; slave ACKs all bytes -> bus bytes 0x78, 0x30, 0x08, 0x82; START/STOP correct; done after 4*4*(2+36)=608 cycles; ack_err=0.
- Read, dev 0x3C, reg 0x300A, N=2; slave returns 0x56, 0x40 -> bytes 0x78, 0x30, 0x0A, RSTART, 0x79; master ACK after byte 0 and NACK after byte 1; rd_data[15:0]=0x4056.
- Slave NACKs the device byte -> no reg bytes sent; STOP follows immediately; done with ack_err=1.
- start pulsed mid-transfer with different dev_addr, plus num_bytes=7 with MAX_BURST=4 -> second start ignored; the first transfer completes with 4 bytes.
- reset asserted during the REGADDR state -> next cycle scl_oe=0, sda_oe=0, busy=0, no done; a new start afterwards works normally.
- rw=1, num_bytes=0 -> no SCL/SDA activity; done and ack_err both 1 on the cycle after capture.
